// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: state encoding and
// the ceiling-log2 helper used to size its counters.
package fifo_uart_tx_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_DATA  = 3'd3,
      ST_STOP  = 3'd4
   } state_t;

   // Never returns less than 1 so a counter for a range of one still has a bit.
   function automatic int clog2(input int value);
      int result;
      result = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// Upstream FIFO read port: the transmitter (master) pops, the FIFO (slave)
// answers with registered read data one cycle later.
interface fifo_uart_tx_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  fifo_rd_en;

   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en
   );
endinterface

// File: rtl/fifo_uart_tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// final cycle of each period with tick.
module baud_counter
   import fifo_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic clear,
   output logic tick
);
   localparam int              CNT_W    = clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] count_reg, count_next;

   assign tick = enable && (count_reg == CNT_LAST);

   // clear wins so every new state starts its period from zero
   always_comb begin
      count_next = count_reg;
      if (clear)
         count_next = '0;
      else if (enable)
         count_next = tick ? '0 : count_reg + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one word per frame from an upstream FIFO with
// registered read data and sends start, DATA_WIDTH bits LSB first, stop.
module fifo_uart_tx
   import fifo_uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic           clk,
   input  logic           reset,
   fifo_uart_tx_if.master fifo,
   output logic           tx,
   output logic           busy,
   output logic           frame_done
);
   localparam int              IDX_W    = clog2(DATA_WIDTH);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

   state_t                state_reg, state_next;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   logic [IDX_W-1:0]      bit_idx_reg, bit_idx_next;
   logic                  tx_reg, tx_next;
   logic                  baud_en, baud_clear, baud_tick;

   baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk    (clk),
      .reset  (reset),
      .enable (baud_en),
      .clear  (baud_clear),
      .tick   (baud_tick)
   );

   assign baud_en    = (state_reg == ST_START) || (state_reg == ST_DATA) ||
                       (state_reg == ST_STOP);
   assign baud_clear = (state_next != state_reg);

   assign fifo.fifo_rd_en = (state_reg == ST_IDLE) && !fifo.fifo_empty && !reset;
   assign busy            = (state_reg != ST_IDLE);
   assign tx              = tx_reg;

   always_comb begin
      state_next   = state_reg;
      data_next    = data_reg;
      bit_idx_next = bit_idx_reg;
      frame_done   = 1'b0;
      tx_next      = 1'b1;

      case (state_reg)
         ST_IDLE: begin
            if (fifo.fifo_rd_en) state_next = ST_LOAD;
         end
         ST_LOAD: begin
            data_next  = fifo.fifo_data;
            state_next = ST_START;
         end
         ST_START: begin
            if (baud_tick) begin
               state_next   = ST_DATA;
               bit_idx_next = '0;
            end
         end
         ST_DATA: begin
            if (baud_tick) begin
               if (bit_idx_reg == IDX_LAST) begin
                  state_next   = ST_STOP;
                  bit_idx_next = '0;
               end else begin
                  bit_idx_next = bit_idx_reg + 1'b1;
               end
            end
         end
         ST_STOP: begin
            if (baud_tick) begin
               state_next = ST_IDLE;
               frame_done = !reset;
            end
         end
         default: state_next = ST_IDLE;
      endcase

      // tx is registered from the upcoming state so the line changes on the
      // same edge the state does
      case (state_next)
         ST_START: tx_next = 1'b0;
         ST_DATA:  tx_next = data_next[bit_idx_next];
         default:  tx_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         data_reg    <= '0;
         bit_idx_reg <= '0;
         tx_reg      <= 1'b1;
      end else begin
         state_reg   <= state_next;
         data_reg    <= data_next;
         bit_idx_reg <= bit_idx_next;
         tx_reg      <= tx_next;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a registered-read FIFO model,
// CLKS_PER_BIT=4 and DATA_WIDTH=8 (40-cycle frames).
module tb_fifo_uart_tx;
   localparam int DW  = 8;
   localparam int CPB = 4;
   localparam int FL  = CPB * (DW + 2);
   localparam logic [FL-1:0] FD_EXP = {1'b1, {(FL-1){1'b0}}};

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tx, busy, frame_done;

   fifo_uart_tx_if #(.DATA_WIDTH(DW)) bif();

   fifo_uart_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo       (bif),
      .tx         (tx),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   // FIFO model: pushes from tasks, pops on sampled rd_en, data one cycle later
   logic [7:0] mem [0:31];
   int         push_n = 0;
   int         pop_n = 0;
   logic [7:0] rd_q = '0;
   logic       ovr_en = 1'b0;
   logic       ovr_val = 1'b0;
   logic       dovr_en = 1'b0;
   logic [7:0] dovr_val = '0;

   assign bif.fifo_empty = ovr_en ? ovr_val : (push_n == pop_n);
   assign bif.fifo_data  = dovr_en ? dovr_val : rd_q;

   always @(posedge clk) begin
      if (bif.fifo_rd_en === 1'b1 && push_n != pop_n) begin
         rd_q  <= mem[pop_n[4:0]];
         pop_n <= pop_n + 1;
      end
   end

   int rd_cnt = 0;
   int fd_cnt = 0;
   int rd_busy = 0;
   always @(negedge clk) begin
      if (bif.fifo_rd_en === 1'b1) begin
         rd_cnt++;
         if (busy !== 1'b0) rd_busy++;
      end
      if (frame_done === 1'b1) fd_cnt++;
   end

   int total = 0;
   int bad = 0;

   task automatic push(input logic [7:0] b);
      mem[push_n[4:0]] = b;
      push_n++;
   endtask

   function automatic logic [FL-1:0] exp_frame(input logic [7:0] b);
      logic [FL-1:0] f;
      f = '1;
      for (int k = 0; k < CPB; k++) f[k] = 1'b0;
      for (int i = 0; i < DW; i++)
         for (int k = 0; k < CPB; k++) f[CPB + i*CPB + k] = b[i];
      return f;
   endfunction

   task automatic capture(output logic [FL-1:0] bits, output logic [FL-1:0] fdv,
                          output int waits, output bit ok);
      bits = '0; fdv = '0; waits = 0; ok = 1'b0;
      while (!ok && waits < 300) begin
         @(negedge clk);
         waits++;
         if (tx === 1'b0) ok = 1'b1;
      end
      if (ok) begin
         bits[0] = tx;
         fdv[0]  = frame_done;
         for (int k = 1; k < FL; k++) begin
            @(negedge clk);
            bits[k] = tx;
            fdv[k]  = frame_done;
         end
      end
   endtask

   task automatic wait_rd(output bit seen);
      int n;
      n = 0;
      #1;
      while (bif.fifo_rd_en !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      seen = (bif.fifo_rd_en === 1'b1);
   endtask

   task automatic wait_idle;
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset;
      ovr_en = 1'b1; ovr_val = 1'b0;
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (bif.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en cyc%0d: got %b want 0", c, bif.fifo_rd_en); end
         total++;
         if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx cyc%0d: got %b want 1", c, tx); end
         total++;
         if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc%0d: got %b want 0", c, busy); end
      end
      reset = 1'b0; ovr_en = 1'b0;
      $display("test_reset: 3 cycles checked");
   endtask

   task automatic test_single;
      logic [FL-1:0] bits, fdv;
      int waits, r0, f0;
      bit ok, seen;
      r0 = rd_cnt; f0 = fd_cnt;
      @(negedge clk);
      push(8'hA5);
      wait_rd(seen);
      total++;
      if (!seen) begin bad++; $display("FAIL single_rd_en: got 0 want 1"); end
      capture(bits, fdv, waits, ok);
      total++;
      if (waits !== 2) begin bad++; $display("FAIL single_latency: got %0d want 2", waits); end
      total++;
      if (bits !== exp_frame(8'hA5)) begin bad++; $display("FAIL single_bits: got %h want %h", bits, exp_frame(8'hA5)); end
      total++;
      if (fdv !== FD_EXP) begin bad++; $display("FAIL single_frame_done: got %h want %h", fdv, FD_EXP); end
      wait_idle();
      total++;
      if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL single_rd_count: got %0d want 1", rd_cnt - r0); end
      total++;
      if (fd_cnt - f0 !== 1) begin bad++; $display("FAIL single_fd_count: got %0d want 1", fd_cnt - f0); end
      $display("test_single: byte a5 tx=%h", bits);
   endtask

   task automatic test_back_to_back;
      logic [7:0] seq [3];
      logic [FL-1:0] bits, fdv;
      int waits, r0, f0;
      bit ok;
      seq = '{8'h01, 8'hFF, 8'h00};
      r0 = rd_cnt; f0 = fd_cnt;
      @(negedge clk);
      for (int j = 0; j < 3; j++) push(seq[j]);
      for (int j = 0; j < 3; j++) begin
         capture(bits, fdv, waits, ok);
         total++;
         if (bits !== exp_frame(seq[j])) begin bad++; $display("FAIL b2b_bits%0d: got %h want %h", j, bits, exp_frame(seq[j])); end
         if (j > 0) begin
            total++;
            if (waits !== 3) begin bad++; $display("FAIL b2b_gap%0d: got %0d idle cycles want 2", j, waits - 1); end
         end
         $display("test_back_to_back: frame %0d byte %h waits=%0d", j, seq[j], waits);
      end
      wait_idle();
      total++;
      if (rd_cnt - r0 !== 3) begin bad++; $display("FAIL b2b_rd_count: got %0d want 3", rd_cnt - r0); end
      total++;
      if (fd_cnt - f0 !== 3) begin bad++; $display("FAIL b2b_fd_count: got %0d want 3", fd_cnt - f0); end
   endtask

   task automatic test_idle_empty;
      int viol, r0;
      viol = 0; r0 = rd_cnt;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || bif.fifo_rd_en !== 1'b0) viol++;
      end
      total++;
      if (viol !== 0) begin bad++; $display("FAIL idle_activity: got %0d bad cycles want 0", viol); end
      total++;
      if (rd_cnt - r0 !== 0) begin bad++; $display("FAIL idle_rd_count: got %0d want 0", rd_cnt - r0); end
      $display("test_idle_empty: 100 cycles, %0d bad", viol);
   endtask

   task automatic test_reset_mid;
      logic [FL-1:0] bits, fdv;
      int waits, r0, lows;
      bit ok;
      r0 = rd_cnt;
      @(negedge clk);
      push(8'h3C);
      push(8'h55);
      waits = 0; ok = 1'b0;
      while (!ok && waits < 300) begin
         @(negedge clk);
         waits++;
         if (tx === 1'b0) ok = 1'b1;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL mid_start: got no start bit want start"); end
      repeat (17) @(negedge clk);   // inside data bit 3
      reset = 1'b1;
      @(negedge clk);
      total++;
      if (tx !== 1'b1) begin bad++; $display("FAIL mid_tx: got %b want 1", tx); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
      total++;
      if (bif.fifo_rd_en !== 1'b0) begin bad++; $display("FAIL mid_rd_en: got %b want 0", bif.fifo_rd_en); end
      reset = 1'b0;
      capture(bits, fdv, waits, ok);
      total++;
      if (bits !== exp_frame(8'h55)) begin bad++; $display("FAIL mid_next_bits: got %h want %h", bits, exp_frame(8'h55)); end
      wait_idle();
      lows = 0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      total++;
      if (lows !== 0) begin bad++; $display("FAIL mid_retransmit: got %0d low cycles want 0", lows); end
      total++;
      if (rd_cnt - r0 !== 2) begin bad++; $display("FAIL mid_rd_count: got %0d want 2", rd_cnt - r0); end
      $display("test_reset_mid: aborted 3c, then 55 tx=%h", bits);
   endtask

   task automatic test_ignore_inputs;
      logic [FL-1:0] bits, fdv;
      int waits, r0, f0;
      bit ok, seen;
      r0 = rd_cnt; f0 = fd_cnt;
      @(negedge clk);
      push(8'hC3);
      wait_rd(seen);
      fork
         capture(bits, fdv, waits, ok);
         begin
            int n;
            n = 0;
            while (tx !== 1'b0 && n < 20) begin
               @(negedge clk);
               n++;
            end
            for (int i = 0; i < 30; i++) begin
               ovr_en   = 1'b1;
               ovr_val  = i[0];
               dovr_en  = 1'b1;
               dovr_val = 8'(i * 37 + 11);
               @(negedge clk);
            end
            ovr_en = 1'b0; dovr_en = 1'b0;
         end
      join
      total++;
      if (bits !== exp_frame(8'hC3)) begin bad++; $display("FAIL ignore_bits: got %h want %h", bits, exp_frame(8'hC3)); end
      wait_idle();
      total++;
      if (rd_cnt - r0 !== 1) begin bad++; $display("FAIL ignore_rd_count: got %0d want 1", rd_cnt - r0); end
      total++;
      if (fd_cnt - f0 !== 1) begin bad++; $display("FAIL ignore_fd_count: got %0d want 1", fd_cnt - f0); end
      total++;
      if (rd_busy !== 0) begin bad++; $display("FAIL rd_en_while_busy: got %0d want 0", rd_busy); end
      $display("test_ignore_inputs: byte c3 tx=%h", bits);
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_idle_empty();
      test_reset_mid();
      test_ignore_inputs();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "simulation timeout");
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning serialized data bits per frame and width of fifo_data.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, meaning clk cycles per serial bit, legal range 2..65535.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port fifo_empty  input  1  upstream FIFO empty flag.
REQ-006 The block SHALL have port fifo_data  input  DATA_WIDTH  upstream FIFO registered read data, valid the cycle after fifo_rd_en is sampled.
REQ-007 The block SHALL have port fifo_rd_en  output  1  pop request to upstream FIFO, sampled by the FIFO on the same rising edge.
REQ-008 The block SHALL have port tx  output  1  serial line, idle high.
REQ-009 The block SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-010 The block SHALL have port frame_done  output  1  single-cycle pulse at completion of each stop bit.

Function
REQ-011 The FSM SHALL have states IDLE, LOAD, START, DATA, STOP.
REQ-012 fifo_rd_en SHALL be combinational: high iff state==IDLE and fifo_empty==0 and reset==0.
REQ-013 In IDLE with fifo_rd_en high, the next state SHALL be LOAD; otherwise remain IDLE.
REQ-014 In LOAD (exactly one cycle), fifo_data SHALL be captured into the shift register; next state START.
REQ-015 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-016 DATA SHALL drive DATA_WIDTH bits LSB first, each for exactly CLKS_PER_BIT cycles, using a bit index counting 0..DATA_WIDTH-1.
REQ-017 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles; on its last cycle frame_done SHALL be 1; next state IDLE.
REQ-018 tx SHALL be a registered output; tx SHALL be 1 in IDLE and LOAD.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1, wrap to 0, and reset to 0 on every state entry.
REQ-020 Pop-to-first-start-bit latency SHALL be 2 cycles: tx falls at the second rising edge after the edge sampling fifo_rd_en.
REQ-021 Back-to-back frames: with FIFO non-empty at STOP exit, the inter-frame gap SHALL be exactly 2 cycles of tx=1 (IDLE, LOAD) beyond the stop bit.
REQ-022 At most one pop SHALL occur per frame; fifo_rd_en SHALL never be high outside IDLE.
REQ-023 fifo_empty changes during LOAD..STOP SHALL have no effect on the current frame.
REQ-024 fifo_data SHALL be sampled only in LOAD; changes at other times SHALL be ignored.

Reset
REQ-025 With reset high at a rising edge: state=IDLE, tx=1, busy=0, frame_done=0, baud counter=0, bit index=0, shift register=0.
REQ-026 fifo_rd_en SHALL be 0 during every cycle reset is high.
REQ-027 Reset mid-frame SHALL abort the frame: tx=1 from the next edge; the popped byte is discarded, never retransmitted.

Structure
REQ-028 A shared package SHALL hold the state encoding constants (IDLE=0, LOAD=1, START=2, DATA=3, STOP=4, 3 bits) and the ceiling-log2 function used to size the baud counter and bit index.
REQ-029 One sub-module, baud_counter (enable, clear, wrap tick at CLKS_PER_BIT-1), SHALL be instantiated; the FSM, shift register and bit index stay in fifo_uart_tx.

Verification (bench with CLKS_PER_BIT=4, DATA_WIDTH=8, model FIFO with registered read)
REQ-030 Reset held 3 cycles with fifo_empty=0 -> fifo_rd_en=0, tx=1, busy=0 throughout.
REQ-031 Single byte 8'hA5 -> one rd_en pulse; tx: start 0 (4 cyc), bits 1,0,1,0,0,1,0,1 (4 cyc each), stop 1 (4 cyc); frame_done once; 40 cycles start-to-stop end.
REQ-032 Bytes 8'h01, 8'hFF, 8'h00 queued -> three frames in order, exactly 2 idle-high cycles between stop end and next start, three rd_en pulses.
REQ-033 FIFO empty throughout -> tx=1, busy=0, no rd_en for 100 cycles.
REQ-034 Reset asserted during DATA bit 3 of 8'h3C -> tx=1 and busy=0 next edge; next queued byte 8'h55 then transmitted fully and correctly.
REQ-035 fifo_empty toggled and fifo_data changed during a frame of 8'hC3 -> transmitted bits unaffected, no extra rd_en.
